// File: rtl/amstrad_mem_pkg.sv
// Shared types for the Amstrad memory bridge: FSM states, bus widths and the
// request-slot record that carries one pending CPU access.
package amstrad_mem_pkg;

    localparam int ADDR_W  = 23;
    localparam int VRAM_AW = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VID_LO = 2'd1,
        VID_HI = 2'd2,
        CPU    = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } slot_t;

endpackage

// File: rtl/amstrad_mem_bridge_if.sv
// Byte-wide req/ack RAM backend bus between the bridge (master) and the
// SDRAM controller (slave).
interface amstrad_mem_bridge_if #(
    parameter int ADDR_W = amstrad_mem_pkg::ADDR_W
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_ack;
    logic [7:0]        ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/amstrad_req_slot.sv
// CPU request capture: rising-edge detect on rd/wr levels feeding a 1-deep
// slot, with a sticky overflow flag for requests that could not be held.
module amstrad_req_slot
    import amstrad_mem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    input  logic              free,
    output logic              full,
    output slot_t             slot,
    output logic              ovf
);

    logic rd_q;
    logic wr_q;
    logic rd_rise;
    logic wr_rise;
    logic req_rise;
    logic accept;

    assign rd_rise  = rd & ~rd_q;
    assign wr_rise  = wr & ~wr_q;
    assign req_rise = rd_rise | wr_rise;
    // A slot freeing this cycle can take the new request immediately.
    assign accept   = req_rise & (~full | free);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            full <= 1'b0;
            slot <= '0;
            ovf  <= 1'b0;
        end else begin
            rd_q <= rd;
            wr_q <= wr;
            if (accept) begin
                full <= 1'b1;
                slot <= '{we: wr_rise, addr: addr, data: wdata};
            end else if (free) begin
                full <= 1'b0;
            end
            // Simultaneous rd+wr loses the read, which counts as a drop.
            if ((req_rise && full && !free) || (rd_rise && wr_rise)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/amstrad_mem_bridge.sv
// Serialises CPU byte accesses and 16-bit video fetches onto one byte-wide
// req/ack RAM backend, video first. MEM_BRIDGE_WP_EN enables write protection.
module amstrad_mem_bridge #(
    parameter int                ADDR_W  = amstrad_mem_pkg::ADDR_W,
    parameter int                VRAM_AW = amstrad_mem_pkg::VRAM_AW,
    parameter logic [ADDR_W-1:0] WP_BASE = 23'h400000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [7:0]          mem_dout,
    input  logic                mem_rd,
    input  logic                mem_wr,
    output logic [7:0]          mem_din,
    input  logic                vram_fetch,
    input  logic [VRAM_AW-1:0]  vram_addr,
    output logic [15:0]         vram_din,
    output logic                cpu_busy,
    output logic                ovf,
    amstrad_mem_bridge_if.master ram
);
    import amstrad_mem_pkg::*;

    localparam int PAD_W = ADDR_W - VRAM_AW - 1;

    state_t             state;
    state_t             state_n;
    slot_t              c_slot;
    logic               c_full;
    logic               c_free;
    logic               wp_hit;
    logic               wp_drop;
    logic               v_full;
    logic               v_renew;
    logic [VRAM_AW-1:0] v_addr;
    logic [VRAM_AW-1:0] v_cur;
    logic               req_d;
    logic               xfer_done;
    logic               lo_done;
    logic               hi_done;
    logic               commit;
    logic [7:0]         lo_shadow;
    logic [7:0]         hi_shadow;

    amstrad_req_slot u_cpu_slot (
        .clk   (clk),
        .reset (reset),
        .rd    (mem_rd),
        .wr    (mem_wr),
        .addr  (mem_addr),
        .wdata (mem_dout),
        .free  (c_free),
        .full  (c_full),
        .slot  (c_slot),
        .ovf   (ovf)
    );

`ifdef MEM_BRIDGE_WP_EN
    assign wp_hit = c_slot.we && (c_slot.addr >= WP_BASE);
`else
    assign wp_hit = 1'b0;
`endif

    // Backend inputs are only meaningful while a request is outstanding.
    assign xfer_done = ram.ram_req & ram.ram_ack;
    assign lo_done   = (state == VID_LO) & xfer_done;
    assign hi_done   = (state == VID_HI) & xfer_done;
    assign wp_drop   = (state == IDLE) & ~v_full & c_full & wp_hit;
    assign c_free    = ((state == CPU) & xfer_done) | wp_drop;
    assign cpu_busy  = c_full | (state == CPU);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (v_full)                 state_n = VID_LO;
                else if (c_full && !wp_hit) state_n = CPU;
            end
            VID_LO:  if (xfer_done) state_n = VID_HI;
            VID_HI:  if (xfer_done) state_n = IDLE;
            CPU:     if (xfer_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        req_d         = 1'b0;
        ram.ram_addr  = '0;
        ram.ram_we    = 1'b0;
        ram.ram_wdata = '0;
        if (state != IDLE) req_d = ~xfer_done;
        case (state)
            VID_LO: ram.ram_addr = {{PAD_W{1'b0}}, v_cur, 1'b0};
            VID_HI: ram.ram_addr = {{PAD_W{1'b0}}, v_cur, 1'b1};
            CPU: begin
                ram.ram_addr  = c_slot.addr;
                ram.ram_we    = c_slot.we;
                ram.ram_wdata = c_slot.we ? c_slot.data : 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram.ram_req <= 1'b0;
            v_full      <= 1'b0;
            v_renew     <= 1'b0;
            v_addr      <= '0;
            v_cur       <= '0;
            lo_shadow   <= 8'h00;
            hi_shadow   <= 8'h00;
            commit      <= 1'b0;
            mem_din     <= 8'h00;
            vram_din    <= 16'h0000;
        end else begin
            ram.ram_req <= req_d;
            commit      <= hi_done;
            if (vram_fetch) v_addr <= vram_addr;
            // A strobe landing during a pair must survive the pair's final ack.
            if (hi_done) begin
                v_full  <= vram_fetch | v_renew;
                v_renew <= 1'b0;
            end else begin
                v_full <= v_full | vram_fetch;
                if (vram_fetch && (state == VID_LO || state == VID_HI ||
                                   (state == IDLE && state_n == VID_LO)))
                    v_renew <= 1'b1;
            end
            if (state == IDLE && state_n == VID_LO) v_cur <= v_addr;
            if (lo_done) lo_shadow <= ram.ram_rdata;
            if (hi_done) hi_shadow <= ram.ram_rdata;
            if (commit)  vram_din  <= {hi_shadow, lo_shadow};
            if ((state == CPU) && xfer_done && !c_slot.we) mem_din <= ram.ram_rdata;
        end
    end

endmodule

// File: tb/tb_amstrad_mem_bridge.sv
// Directed-vector bench for amstrad_mem_bridge; honours MEM_BRIDGE_WP_EN.
module tb_amstrad_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [22:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        vram_fetch;
    logic [14:0] vram_addr;
    logic [15:0] vram_din;
    logic        cpu_busy;
    logic        ovf;

    int vectors     = 0;
    int miscompares = 0;
    int req_rises   = 0;
    logic req_prev  = 1'b0;

    amstrad_mem_bridge_if #(.ADDR_W(23)) ram_if ();

    amstrad_mem_bridge dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_din    (mem_din),
        .vram_fetch (vram_fetch),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .cpu_busy   (cpu_busy),
        .ovf        (ovf),
        .ram        (ram_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_if.ram_req && !req_prev) req_rises++;
        req_prev = ram_if.ram_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output logic ok);
        int n;
        n = 0;
        while (!ram_if.ram_req && n < 20) begin
            tick();
            n++;
        end
        ok = ram_if.ram_req;
    endtask

    task automatic ack_byte(input logic [7:0] d);
        ram_if.ram_ack   = 1'b1;
        ram_if.ram_rdata = d;
        tick();
        ram_if.ram_ack   = 1'b0;
        ram_if.ram_rdata = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", ram_if.ram_req); end
        vectors++; if (ram_if.ram_addr !== 23'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", ram_if.ram_addr); end
        vectors++; if (mem_din !== 8'h00) begin miscompares++; $display("FAIL rst_mem_din: got %h want 00", mem_din); end
        vectors++; if (vram_din !== 16'h0000) begin miscompares++; $display("FAIL rst_vram_din: got %h want 0000", vram_din); end
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", cpu_busy); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_idle_read();
        int base;
        base     = req_rises;
        mem_addr = 23'h00C123;
        mem_rd   = 1'b1;
        tick();
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL rd_busy: got %b want 1", cpu_busy); end
        tick();
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_early: got %b want 0", ram_if.ram_req); end
        tick();
        vectors++; if (ram_if.ram_req !== 1'b1) begin miscompares++; $display("FAIL rd_req: got %b want 1", ram_if.ram_req); end
        vectors++; if (ram_if.ram_we !== 1'b0) begin miscompares++; $display("FAIL rd_we: got %b want 0", ram_if.ram_we); end
        vectors++; if (ram_if.ram_addr !== 23'h00C123) begin miscompares++; $display("FAIL rd_addr: got %h want 00c123", ram_if.ram_addr); end
        ack_byte(8'h5A);
        vectors++; if (mem_din !== 8'h5A) begin miscompares++; $display("FAIL rd_data_3clk: got %h want 5a", mem_din); end
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_drop: got %b want 0", ram_if.ram_req); end
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL rd_busy_clear: got %b want 0", cpu_busy); end
        mem_rd = 1'b0;
        tick();
        tick();
        vectors++; if (req_rises - base !== 1) begin miscompares++; $display("FAIL rd_req_count: got %0d want 1", req_rises - base); end
    endtask

    task automatic test_video();
        logic ok;
        vram_addr  = 15'h1234;
        vram_fetch = 1'b1;
        tick();
        vram_fetch = 1'b0;
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h002468) begin miscompares++; $display("FAIL vid_lo_addr: got %h (req %b) want 002468", ram_if.ram_addr, ok); end
        vectors++; if (ram_if.ram_we !== 1'b0) begin miscompares++; $display("FAIL vid_we: got %b want 0", ram_if.ram_we); end
        ack_byte(8'h11);
        vectors++; if (vram_din !== 16'h0000) begin miscompares++; $display("FAIL vid_partial_lo: got %h want 0000", vram_din); end
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h002469) begin miscompares++; $display("FAIL vid_hi_addr: got %h (req %b) want 002469", ram_if.ram_addr, ok); end
        ack_byte(8'h22);
        vectors++; if (vram_din !== 16'h0000) begin miscompares++; $display("FAIL vid_partial_hi: got %h want 0000", vram_din); end
        tick();
        vectors++; if (vram_din !== 16'h2211) begin miscompares++; $display("FAIL vid_word: got %h want 2211", vram_din); end
    endtask

    task automatic test_collision();
        logic ok;
        vram_addr  = 15'h0100;
        vram_fetch = 1'b1;
        mem_addr   = 23'h000010;
        mem_dout   = 8'hA5;
        mem_wr     = 1'b1;
        tick();
        vram_fetch = 1'b0;
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL col_busy_start: got %b want 1", cpu_busy); end
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h000200) begin miscompares++; $display("FAIL col_vid_first: got %h (req %b) want 000200", ram_if.ram_addr, ok); end
        ack_byte(8'h33);
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h000201) begin miscompares++; $display("FAIL col_vid_hi: got %h (req %b) want 000201", ram_if.ram_addr, ok); end
        ack_byte(8'h44);
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL col_busy_mid: got %b want 1", cpu_busy); end
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h000010) begin miscompares++; $display("FAIL col_wr_addr: got %h (req %b) want 000010", ram_if.ram_addr, ok); end
        vectors++; if (ram_if.ram_we !== 1'b1) begin miscompares++; $display("FAIL col_wr_we: got %b want 1", ram_if.ram_we); end
        vectors++; if (ram_if.ram_wdata !== 8'hA5) begin miscompares++; $display("FAIL col_wr_data: got %h want a5", ram_if.ram_wdata); end
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL col_busy_wr: got %b want 1", cpu_busy); end
        ack_byte(8'hFF);
        mem_wr = 1'b0;
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL col_busy_end: got %b want 0", cpu_busy); end
        vectors++; if (mem_din !== 8'h5A) begin miscompares++; $display("FAIL col_mem_din_kept: got %h want 5a", mem_din); end
        vectors++; if (vram_din !== 16'h4433) begin miscompares++; $display("FAIL col_vram_din: got %h want 4433", vram_din); end
        tick();
    endtask

    task automatic test_overflow();
        mem_addr = 23'h000100;
        mem_rd   = 1'b1;
        tick();
        mem_rd = 1'b0;
        tick();
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", ovf); end
        mem_rd = 1'b1;
        tick();
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", ovf); end
        vectors++; if (ram_if.ram_req !== 1'b1) begin miscompares++; $display("FAIL ovf_stalled_req: got %b want 1", ram_if.ram_req); end
        tick();
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        reset  = 1'b1;
        mem_rd = 1'b0;
        tick();
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL ovf_rst_req: got %b want 0", ram_if.ram_req); end
        reset = 1'b0;
        tick();
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_rst_clear: got %b want 0", ovf); end
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL ovf_rst_busy: got %b want 0", cpu_busy); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        mem_addr = 23'h000123;
        mem_rd   = 1'b1;
        tick();
        wait_req(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rstmid_req_up: got %b want 1", ok); end
        mem_rd = 1'b0;
        reset  = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_drop: got %b want 0", ram_if.ram_req); end
        ack_byte(8'hEE);
        vectors++; if (mem_din !== 8'h00) begin miscompares++; $display("FAIL rstmid_late_ack: got %h want 00", mem_din); end
        tick();
        tick();
        vectors++; if (ram_if.ram_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req_idle: got %b want 0", ram_if.ram_req); end
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", cpu_busy); end
    endtask

    task automatic test_write_protect();
        logic ok;
        int   base;
        base     = req_rises;
        mem_addr = 23'h400000;
        mem_dout = 8'h77;
        mem_wr   = 1'b1;
        tick();
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL wp_busy_set: got %b want 1", cpu_busy); end
        mem_wr = 1'b0;
        tick();
`ifdef MEM_BRIDGE_WP_EN
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL wp_busy_1clk: got %b want 0", cpu_busy); end
        tick();
        tick();
        tick();
        vectors++; if (req_rises - base !== 0) begin miscompares++; $display("FAIL wp_no_req: got %0d want 0", req_rises - base); end
`else
        vectors++; if (cpu_busy !== 1'b1) begin miscompares++; $display("FAIL wp_busy_held: got %b want 1", cpu_busy); end
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h400000) begin miscompares++; $display("FAIL wp_off_addr: got %h (req %b) want 400000", ram_if.ram_addr, ok); end
        vectors++; if (ram_if.ram_wdata !== 8'h77) begin miscompares++; $display("FAIL wp_off_data: got %h want 77", ram_if.ram_wdata); end
        ack_byte(8'h00);
`endif
        mem_addr = 23'h3FFFFF;
        mem_dout = 8'h66;
        mem_wr   = 1'b1;
        tick();
        mem_wr = 1'b0;
        wait_req(ok);
        vectors++; if (ok !== 1'b1 || ram_if.ram_addr !== 23'h3FFFFF) begin miscompares++; $display("FAIL wp_below_addr: got %h (req %b) want 3fffff", ram_if.ram_addr, ok); end
        vectors++; if (ram_if.ram_we !== 1'b1) begin miscompares++; $display("FAIL wp_below_we: got %b want 1", ram_if.ram_we); end
        vectors++; if (ram_if.ram_wdata !== 8'h66) begin miscompares++; $display("FAIL wp_below_data: got %h want 66", ram_if.ram_wdata); end
        ack_byte(8'h00);
        vectors++; if (cpu_busy !== 1'b0) begin miscompares++; $display("FAIL wp_below_busy: got %b want 0", cpu_busy); end
        tick();
        tick();
`ifdef MEM_BRIDGE_WP_EN
        vectors++; if (req_rises - base !== 1) begin miscompares++; $display("FAIL wp_req_count: got %0d want 1", req_rises - base); end
`else
        vectors++; if (req_rises - base !== 2) begin miscompares++; $display("FAIL wp_req_count: got %0d want 2", req_rises - base); end
`endif
    endtask

    initial begin
        reset            = 1'b1;
        mem_addr         = '0;
        mem_dout         = 8'h00;
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        vram_fetch       = 1'b0;
        vram_addr        = '0;
        ram_if.ram_ack   = 1'b0;
        ram_if.ram_rdata = 8'h00;

        test_reset();
        test_idle_read();
        test_video();
        test_collision();
        test_overflow();
        test_reset_mid();
        test_write_protect();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
